// File: rtl/loop_add_seven.sv
// Self-running kernel: after reset release it computes a[i] = b[i] + ADDEND for
// i = 0..N-1 in an embedded RAM, pulses valid once, then halts until the next reset.
module loop_add_seven #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N      = 2,
  parameter int ADDEND = 7,
  parameter int A_BASE = 0,
  parameter int B_BASE = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] debug_write_addr,
  input  logic [DATA_W-1:0] debug_write_data,
  input  logic              debug_write_en,
  input  logic [ADDR_W-1:0] debug_addr,
  output logic [DATA_W-1:0] debug_data,
  output logic              valid,
  output logic [ADDR_W-1:0] ram_waddr_0,
  output logic [DATA_W-1:0] ram_wdata_0,
  output logic              ram_wen_0,
  output logic [ADDR_W-1:0] ram_raddr_0,
  output logic [DATA_W-1:0] ram_rdata_0
);

  localparam int          I_W    = $clog2(N + 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_ADD,
    S_WR,
    S_CHK,
    S_DONE,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [I_W-1:0]    r_i;
  logic [DATA_W-1:0] r_rdreg;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_rdreg <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_RD:    r_rdreg <= ram_rdata_0;
        S_ADD:   r_sum   <= r_rdreg + DATA_W'(ADDEND);
        S_CHK:   if (r_i != I_LAST) r_i <= r_i + I_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RD;
      S_RD:    w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_WR;
      S_WR:    w_state_nxt = S_CHK;
      S_CHK:   w_state_nxt = (r_i == I_LAST) ? S_DONE : S_RD;
      S_DONE:  w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Kernel-side outputs depend only on registered state, never on debug inputs.
  assign ram_raddr_0 = ADDR_W'(B_BASE) + ADDR_W'(r_i);
  assign ram_waddr_0 = ADDR_W'(A_BASE) + ADDR_W'(r_i);
  assign ram_wdata_0 = r_sum;
  assign ram_wen_0   = (r_state == S_WR);
  assign valid       = (r_state == S_DONE);

  // NOTE: the RAM array has no reset, so it maps onto plain storage and a
  // preload done while the kernel is held in reset survives the release.
  always_ff @(posedge clk) begin
    if (debug_write_en) begin
      r_mem[debug_write_addr] <= debug_write_data;
    end else if (ram_wen_0) begin
      r_mem[ram_waddr_0] <= ram_wdata_0;
    end
  end

  assign ram_rdata_0 = r_mem[ram_raddr_0];
  assign debug_data  = r_mem[debug_addr];

endmodule

// File: tb/tb_loop_add_seven.sv
// Randomized self-checking bench for loop_add_seven against a reference model
// that holds the expected RAM image and the expected per-edge write/valid schedule.
module tb_loop_add_seven;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] debug_write_addr;
  logic [DATA_W-1:0] debug_write_data;
  logic              debug_write_en;
  logic [ADDR_W-1:0] debug_addr;
  logic [DATA_W-1:0] debug_data;
  logic              valid;
  logic [ADDR_W-1:0] ram_waddr_0;
  logic [DATA_W-1:0] ram_wdata_0;
  logic              ram_wen_0;
  logic [ADDR_W-1:0] ram_raddr_0;
  logic [DATA_W-1:0] ram_rdata_0;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_mem [32];
  logic [DATA_W-1:0] exp_a [2];
  logic [DATA_W-1:0] cur_b [2];

  loop_add_seven dut (
    .clk              (clk),
    .rst              (rst),
    .debug_write_addr (debug_write_addr),
    .debug_write_data (debug_write_data),
    .debug_write_en   (debug_write_en),
    .debug_addr       (debug_addr),
    .debug_data       (debug_data),
    .valid            (valid),
    .ram_waddr_0      (ram_waddr_0),
    .ram_wdata_0      (ram_wdata_0),
    .ram_wen_0        (ram_wen_0),
    .ram_raddr_0      (ram_raddr_0),
    .ram_rdata_0      (ram_rdata_0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    debug_write_addr = addr;
    debug_write_data = data;
    debug_write_en   = 1'b1;
    tick();
    debug_write_en   = 1'b0;
    model_mem[addr]  = data;
  endtask

  task automatic dbg_read(input string tag, input logic [ADDR_W-1:0] addr);
    debug_addr = addr;
    #1;
    check(tag, debug_data, model_mem[addr]);
  endtask

  // Hold the kernel in reset, scribble over a[], preload b[] and derive expectations.
  task automatic load(input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1);
    rst = 1'b0;
    #1;
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_wen", {31'b0, ram_wen_0}, 0);
    dbg_write(5'd0, $urandom);
    dbg_write(5'd1, $urandom);
    dbg_write(5'd10, b0);
    dbg_write(5'd11, b1);
    cur_b[0] = b0;
    cur_b[1] = b1;
    exp_a[0] = b0 + 32'd7;
    exp_a[1] = b1 + 32'd7;
  endtask

  // Release reset and check the kernel edge by edge; k names the edge that ends the cycle.
  task automatic run(input bit collide);
    logic exp_wen;
    int   idx;
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      exp_wen = (k == 4) || (k == 8);
      idx     = (k <= 4) ? 0 : 1;
      check("wen", {31'b0, ram_wen_0}, {31'b0, exp_wen});
      check("valid", {31'b0, valid}, (k == 10) ? 1 : 0);
      if (exp_wen) begin
        check("waddr", {27'b0, ram_waddr_0}, idx);
        check("wdata", ram_wdata_0, exp_a[idx]);
      end
      if (k == 2 || k == 6) begin
        check("raddr", {27'b0, ram_raddr_0}, 10 + idx);
        check("rdata", ram_rdata_0, cur_b[idx]);
      end
      if (collide && k == 4) begin
        debug_write_addr = 5'd0;
        debug_write_data = 32'd99;
        debug_write_en   = 1'b1;
      end
      tick();
      debug_write_en = 1'b0;
      if (exp_wen) model_mem[idx] = (collide && k == 4) ? 32'd99 : exp_a[idx];
    end
    for (int k = 0; k < 20; k++) begin
      check("halt_valid", {31'b0, valid}, 0);
      check("halt_wen", {31'b0, ram_wen_0}, 0);
      tick();
    end
    dbg_read("mem_a0", 5'd0);
    dbg_read("mem_a1", 5'd1);
    dbg_read("mem_b0", 5'd10);
    dbg_read("mem_b1", 5'd11);
  endtask

  initial begin
    rst              = 1'b0;
    debug_write_addr = '0;
    debug_write_data = '0;
    debug_write_en   = 1'b0;
    debug_addr       = '0;
    for (int j = 0; j < 32; j++) model_mem[j] = 'x;

    // Directed preload from the basic use case, then carry wrap.
    load(32'd10, 32'd5);
    run(1'b0);
    load(32'hFFFF_FFFC, 32'd0);
    run(1'b0);

    // Debug write to a[0] in the same cycle the kernel commits a[0].
    load(32'd10, 32'd5);
    run(1'b1);

    // Abort after a[0] is committed, then restart from the same b[].
    load(32'd10, 32'd5);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b0;
    #1;
    check("abort_valid", {31'b0, valid}, 0);
    check("abort_wen", {31'b0, ram_wen_0}, 0);
    model_mem[0] = exp_a[0];
    dbg_read("abort_a0_kept", 5'd0);
    dbg_read("abort_a1_old", 5'd1);
    tick();
    run(1'b0);

    // Random operands, including values near the wrap point.
    for (int t = 0; t < 6; t++) begin
      logic [DATA_W-1:0] r0, r1;
      r0 = $urandom;
      r1 = (t % 2 == 0) ? 32'hFFFF_FFF9 + $urandom_range(0, 6) : $urandom;
      load(r0, r1);
      run(t == 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
